// File: rtl/step_pkg.sv
// Shared types and constants for the step controller.
package step_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned RUN_DIV_DEF         = 50000000;
    localparam int unsigned CYCLE_CNT_W         = 32;

    typedef enum logic [1:0] {
        WAIT_PRESS   = 2'd0,
        PRESSED      = 2'd1,
        WAIT_RELEASE = 2'd2
    } step_state_e;

endpackage

// File: rtl/step_ctrl_if.sv
// Button/switch inputs and step outputs of the step controller.
interface step_ctrl_if
    import step_pkg::*;
;
    logic                   BtnStep;
    logic                   ModeRun;
    logic                   StepEn;
    logic                   Running;
    logic [CYCLE_CNT_W-1:0] CycleCount;

    modport master (
        output BtnStep,
        output ModeRun,
        input  StepEn,
        input  Running,
        input  CycleCount
    );

    modport slave (
        input  BtnStep,
        input  ModeRun,
        output StepEn,
        output Running,
        output CycleCount
    );
endinterface

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchronizer plus stability counter; level changes only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current level.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = step_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;

    // Metastability synchronizer for the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Stability counter: clear on agreement, toggle level at terminal count
    always_comb begin
        cnt_d   = '0;
        level_d = level;
        if (sync2_q != level) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounced level and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            level <= level_d;
        end
    end
endmodule

// File: rtl/step_ctrl.sv
// Step-enable generator: one pulse per debounced press in single-step mode,
// periodic pulses from a divider in run mode.
// Optional feature macro: STEP_COUNTER_EN builds the CycleCount counter;
// without it CycleCount is tied to zero.
module step_ctrl
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned RUN_DIV         = RUN_DIV_DEF
) (
    input logic        Clk,
    input logic        Reset,
    step_ctrl_if.slave bus
);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    logic             db_level;
    logic             mode_s1_q;
    logic             mode_s2_q;
    logic             running_q;
    step_state_e      state_q;
    step_state_e      state_d;
    logic             step_q;
    logic             step_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (Clk),
        .rst_n(Reset),
        .din  (bus.BtnStep),
        .level(db_level)
    );

    // Plain synchronizer and registered copy of the run/step switch
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            mode_s1_q <= bus.ModeRun;
            mode_s2_q <= mode_s1_q;
            running_q <= mode_s2_q;
        end
    end

    // FSM, divider and step decision; leaving run mode kills the pulse
    // in the same cycle Running falls
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        div_d   = '0;
        if (running_q) begin
            state_d = db_level ? WAIT_RELEASE : WAIT_PRESS;
            if (mode_s2_q) begin
                step_d = (div_q == DIV_MAX);
                div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
            end
        end else begin
            case (state_q)
                WAIT_PRESS: begin
                    if (db_level) begin
                        state_d = PRESSED;
                        step_d  = 1'b1;
                    end
                end
                PRESSED: begin
                    state_d = WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!db_level) begin
                        state_d = WAIT_PRESS;
                    end
                end
                default: begin
                    state_d = WAIT_PRESS;
                end
            endcase
        end
    end

    // State, divider and step pulse registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= WAIT_PRESS;
            div_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
        end
    end

    assign bus.StepEn  = step_q;
    assign bus.Running = running_q;

`ifdef STEP_COUNTER_EN
    logic [CYCLE_CNT_W-1:0] cycle_count_q;

    // Count issued step pulses, wrapping naturally
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_q + CYCLE_CNT_W'(step_q);
        end
    end

    assign bus.CycleCount = cycle_count_q;
`else
    assign bus.CycleCount = '0;
`endif
endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5.
module tb_step_ctrl;
    import step_pkg::*;

    localparam int unsigned DC = 4;
    localparam int unsigned RD = 5;
    // Clean press edge to StepEn: 2 sync + DC debounce + 1 FSM
    localparam int PRESS_LAT = 2 + DC + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] exp_count = 32'd0;

    step_ctrl_if bus ();

    step_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .RUN_DIV        (RD)
    ) dut (
        .Clk  (clk),
        .Reset(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef STEP_COUNTER_EN
        return exp_count;
`else
        return 32'd0;
`endif
    endfunction

    // Run n cycles expecting a single StepEn pulse at cycle pulse_at (0: none)
    task automatic watch(input string tag, input int n, input int pulse_at);
        for (int i = 1; i <= n; i++) begin
            next_cycle();
            chk(tag, 32'(bus.StepEn), 32'(i == pulse_at));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.BtnStep = 1'b0;
        bus.ModeRun = 1'b0;
        repeat (3) next_cycle();
        chk("rst StepEn", 32'(bus.StepEn), 32'd0);
        chk("rst Running", 32'(bus.Running), 32'd0);
        chk("rst CycleCount", bus.CycleCount, 32'd0);
        rst_n = 1'b1;

        // Idle after reset
        watch("idle StepEn", 20, 0);
        chk("idle Running", 32'(bus.Running), 32'd0);
        chk("idle CycleCount", bus.CycleCount, 32'd0);

        // Clean single-step press: 12 cycles high, then released
        bus.BtnStep = 1'b1;
        watch("press StepEn", 12, PRESS_LAT);
        exp_count++;
        bus.BtnStep = 1'b0;
        watch("press release StepEn", 12, 0);
        chk("press CycleCount", bus.CycleCount, cnt_exp());

        // Bounce: 2-cycle toggles never reach 4 stable samples
        for (int j = 0; j < 20; j++) begin
            bus.BtnStep = ((j / 2) % 2) == 0;
            next_cycle();
            chk("bounce StepEn", 32'(bus.StepEn), 32'd0);
        end
        bus.BtnStep = 1'b1;
        watch("bounce hold StepEn", 12, PRESS_LAT);
        exp_count++;
        bus.BtnStep = 1'b0;
        watch("bounce release StepEn", 12, 0);
        chk("bounce CycleCount", bus.CycleCount, cnt_exp());

        // Run mode: Running at +3, pulses at +8, +13, ... ; button held from +10
        bus.ModeRun = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) bus.BtnStep = 1'b1;
            next_cycle();
            chk("run Running", 32'(bus.Running), 32'(i >= 3));
            chk("run StepEn", 32'(bus.StepEn), 32'((i >= 8) && ((i - 8) % 5 == 0)));
        end
        exp_count += 5;
        chk("run CycleCount", bus.CycleCount, cnt_exp());

        // Leave run mode with the button held: pulse due at +3 is suppressed
        bus.ModeRun = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            chk("leave Running", 32'(bus.Running), 32'(k < 3));
            chk("leave StepEn", 32'(bus.StepEn), 32'd0);
        end
        bus.BtnStep = 1'b0;
        watch("leave release StepEn", 10, 0);
        bus.BtnStep = 1'b1;
        watch("repress StepEn", 12, PRESS_LAT);
        exp_count++;
        bus.BtnStep = 1'b0;
        watch("repress release StepEn", 10, 0);
        chk("repress CycleCount", bus.CycleCount, cnt_exp());

        // Reset during debounce discards progress
        bus.BtnStep = 1'b1;
        repeat (4) next_cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst StepEn", 32'(bus.StepEn), 32'd0);
        chk("midrst Running", 32'(bus.Running), 32'd0);
        chk("midrst CycleCount", bus.CycleCount, 32'd0);
        exp_count   = 32'd0;
        bus.BtnStep = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        watch("postrst StepEn", 12, 0);
        chk("postrst CycleCount", bus.CycleCount, 32'd0);
        chk("postrst Running", 32'(bus.Running), 32'd0);

`ifdef STEP_COUNTER_EN
        // Counter wrap from all-ones
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count_q;
        chk("wrap preload", bus.CycleCount, 32'hFFFF_FFFF);
        bus.BtnStep = 1'b1;
        watch("wrap StepEn", 8, PRESS_LAT);
        chk("wrap CycleCount", bus.CycleCount, 32'd0);
        bus.BtnStep = 1'b0;
        watch("wrap release StepEn", 10, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
